// File: rtl/sequencer_group_mgr.sv
// Group scheduler for NUM_RAILS rail sequencers: ordered power-up,
// reverse power-down, step timeouts, bounded retry and fault lockout.
module sequencer_group_mgr #(
  parameter int NUM_RAILS   = 4,
  parameter int DLY_STEP_TO = 200,
  parameter int DLY_RETRY   = 1000,
  parameter int MAX_RETRIES = 2,
  parameter int C_CNTRSIZE  = 12,
  localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
  input  logic                 CLOCK,
  input  logic                 RESET,
  input  logic                 PWR_REQ,
  input  logic                 FAULT_CLR,
  input  logic [NUM_RAILS-1:0] RAIL_NEXT_OE,
  input  logic [NUM_RAILS-1:0] RAIL_FAULT,
  input  logic [NUM_RAILS-1:0] RAIL_PWRGD,
  output logic [NUM_RAILS-1:0] RAIL_ENABLE,
  output logic [NUM_RAILS-1:0] GROUP_PWRGD_HI,
  output logic                 SYS_PWROK,
  output logic                 FAULT_LATCHED,
  output logic [NUM_RAILS-1:0] FAULT_RAIL,
  output logic [RW-1:0]        RETRY_CNT
);

  localparam int IW = $clog2(NUM_RAILS);
  localparam logic [IW-1:0] LAST = IW'(NUM_RAILS - 1);
  localparam logic [C_CNTRSIZE-1:0] STEP_TO = C_CNTRSIZE'(DLY_STEP_TO);
  localparam logic [C_CNTRSIZE-1:0] RTRY_TO = C_CNTRSIZE'(DLY_RETRY);
  localparam logic [RW-1:0] MAXR = RW'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_OFF, S_UP, S_ON, S_DOWN, S_RETRY, S_LOCK
  } state_t;

  state_t                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [C_CNTRSIZE-1:0] cnt_q, cnt_d;
  logic                  fp_q, fp_d;
  logic [RW-1:0]         retry_q, retry_d;
  logic [NUM_RAILS-1:0]  frail_q, frail_d;
  logic [NUM_RAILS-1:0]  en_q, en_d;
  logic [NUM_RAILS-1:0]  ghi_q, ghi_d;
  logic                  pwrok_q, pwrok_d;
  logic                  lock_q, lock_d;

  logic step_to, any_flt, up_to, dn_to;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    fp_d    = fp_q;
    retry_d = retry_q;
    frail_d = frail_q;
    step_to = cnt_q >= STEP_TO;
    any_flt = |RAIL_FAULT;
    up_to   = step_to && !RAIL_NEXT_OE[idx_q];
    dn_to   = step_to && RAIL_PWRGD[idx_q];
    unique case (state_q)
      S_OFF: begin
        if (PWR_REQ && !lock_q) begin
          state_d = S_UP;
          idx_d   = '0;
          frail_d = '0;
        end
      end
      S_UP: begin
        // fault outranks both abort and step advance
        if (any_flt || up_to) begin
          frail_d = frail_q | RAIL_FAULT;
          if (up_to) frail_d[idx_q] = 1'b1;
          fp_d    = 1'b1;
          state_d = S_DOWN;
        end else if (!PWR_REQ) begin
          state_d = S_DOWN;
        end else if (RAIL_NEXT_OE[idx_q]) begin
          if (idx_q == LAST) begin
            state_d = S_ON;
            retry_d = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_ON: begin
        if (any_flt) begin
          frail_d = frail_q | RAIL_FAULT;
          fp_d    = 1'b1;
          state_d = S_DOWN;
          idx_d   = LAST;
        end else if (!PWR_REQ) begin
          state_d = S_DOWN;
          idx_d   = LAST;
        end
      end
      S_DOWN: begin
        if (!RAIL_PWRGD[idx_q] || dn_to) begin
          if (dn_to) begin
            frail_d[idx_q] = 1'b1;
            fp_d           = 1'b1;
          end
          if (idx_q != '0) begin
            idx_d = idx_q - 1'b1;
          end else begin
            fp_d = 1'b0;
            if (!(fp_q || dn_to)) begin
              state_d = S_OFF;
            end else if (retry_q < MAXR) begin
              state_d = S_RETRY;
              retry_d = retry_q + 1'b1;
            end else begin
              state_d = S_LOCK;
            end
          end
        end
      end
      S_RETRY: begin
        if (cnt_q >= RTRY_TO) begin
          state_d = PWR_REQ ? S_UP : S_OFF;
          idx_d   = '0;
        end
      end
      S_LOCK: begin
        if (FAULT_CLR && !PWR_REQ) begin
          state_d = S_OFF;
          retry_d = '0;
          frail_d = '0;
        end
      end
      default: state_d = S_OFF;
    endcase
  end

  always_comb begin
    if (state_d != state_q || idx_d != idx_q) cnt_d = '0;
    else if (&cnt_q) cnt_d = cnt_q;
    else cnt_d = cnt_q + 1'b1;
  end

  // outputs decode the next state so they land on the transition edge
  always_comb begin
    en_d  = '0;
    ghi_d = '0;
    for (int i = 0; i < NUM_RAILS; i++) begin
      unique case (state_d)
        S_UP:    en_d[i] = IW'(i) <= idx_d;
        S_ON:    en_d[i] = 1'b1;
        S_DOWN:  en_d[i] = IW'(i) < idx_d;
        default: en_d[i] = 1'b0;
      endcase
      ghi_d[i] = |(RAIL_PWRGD >> (i + 1));
    end
    pwrok_d = state_d == S_ON;
    lock_d  = state_d == S_LOCK;
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q <= S_OFF;
      idx_q   <= '0;
      cnt_q   <= '0;
      fp_q    <= 1'b0;
      retry_q <= '0;
      frail_q <= '0;
      en_q    <= '0;
      ghi_q   <= '0;
      pwrok_q <= 1'b0;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      fp_q    <= fp_d;
      retry_q <= retry_d;
      frail_q <= frail_d;
      en_q    <= en_d;
      ghi_q   <= ghi_d;
      pwrok_q <= pwrok_d;
      lock_q  <= lock_d;
    end
  end

  assign RAIL_ENABLE    = en_q;
  assign GROUP_PWRGD_HI = ghi_q;
  assign SYS_PWROK      = pwrok_q;
  assign FAULT_LATCHED  = lock_q;
  assign FAULT_RAIL     = frail_q;
  assign RETRY_CNT      = retry_q;

endmodule

// File: tb/tb_sequencer_group_mgr.sv
// Bench for sequencer_group_mgr: behavioural rail models with random
// latencies; expected event times derived from the sequencing rules.
module tb_sequencer_group_mgr;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req = 1'b0;
  logic fclr = 1'b0;
  logic [N-1:0] noe = '0;
  logic [N-1:0] rflt = '0;
  logic [N-1:0] pg = '0;
  logic [N-1:0] en, ghi, frail;
  logic pwrok, flat;
  logic [1:0] rc;

  always #5 clk = ~clk;

  sequencer_group_mgr #(
    .NUM_RAILS(4), .DLY_STEP_TO(20), .DLY_RETRY(50),
    .MAX_RETRIES(2), .C_CNTRSIZE(12)
  ) dut (
    .CLOCK(clk), .RESET(rst), .PWR_REQ(req), .FAULT_CLR(fclr),
    .RAIL_NEXT_OE(noe), .RAIL_FAULT(rflt), .RAIL_PWRGD(pg),
    .RAIL_ENABLE(en), .GROUP_PWRGD_HI(ghi), .SYS_PWROK(pwrok),
    .FAULT_LATCHED(flat), .FAULT_RAIL(frail), .RETRY_CNT(rc)
  );

  int vec = 0;
  int bad = 0;
  int cyc = 0;
  int oe_lat[N], dn_lat[N], f_lat[N];
  bit hang[N], flt_on[N];
  int age[N], off_age[N];
  int rise_t[N], fall_t[N], rise_n[N];
  logic [N-1:0] en_prev = '0;
  int pok_t = 0;
  logic pok_prev = 1'b0;
  logic [1:0] rc_prev = '0;
  int rc_t = 0;

  // one clock: sample DUT after the edge, then advance the rail models
  task automatic tick();
    logic rs;
    logic [N-1:0] pgs, eg, tp;
    rs = rst;
    pgs = pg;
    @(posedge clk);
    #1;
    cyc++;
    if (!rs) begin
      for (int i = 0; i < N; i++) begin
        eg[i] = 1'b0;
        for (int j = i + 1; j < N; j++) eg[i] = eg[i] | pgs[j];
      end
      vec++;
      if (ghi !== eg) begin
        bad++;
        $display("FAIL ghi_lag cyc=%0d got=%b exp=%b", cyc, ghi, eg);
      end
    end
    tp = en + 1'b1;
    vec++;
    if ((tp & en) !== '0) begin
      bad++;
      $display("FAIL en_order cyc=%0d got=%b exp=prefix", cyc, en);
    end
    for (int i = 0; i < N; i++) begin
      if (en[i]) begin
        age[i]++;
        off_age[i] = 0;
        if (!en_prev[i]) begin
          rise_t[i] = cyc;
          rise_n[i]++;
        end
        pg[i] = 1'b1;
      end else begin
        age[i] = 0;
        off_age[i]++;
        if (en_prev[i]) fall_t[i] = cyc;
        if (off_age[i] > dn_lat[i]) pg[i] = 1'b0;
      end
      noe[i] = en[i] && !hang[i] && age[i] > oe_lat[i];
      rflt[i] = en[i] && flt_on[i] && age[i] > f_lat[i];
    end
    en_prev = en;
    if (pwrok && !pok_prev) pok_t = cyc;
    pok_prev = pwrok;
    if (rc !== rc_prev) rc_t = cyc;
    rc_prev = rc;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ticks(2);
    vec++;
    if (en !== 4'b0) begin
      bad++; $display("FAIL rst_en got=%b exp=0000", en);
    end
    vec++;
    if (ghi !== 4'b0) begin
      bad++; $display("FAIL rst_ghi got=%b exp=0000", ghi);
    end
    vec++;
    if ({pwrok, flat, frail, rc} !== 8'b0) begin
      bad++;
      $display("FAIL rst_status got=%b%b %b %0d exp=0", pwrok, flat, frail, rc);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_nominal_up();
    int t0;
    for (int i = 0; i < N; i++) oe_lat[i] = $urandom_range(1, 5);
    req = 1'b1;
    t0 = cyc;
    for (int k = 0; k < 100 && pwrok !== 1'b1; k++) tick();
    vec++;
    if (pwrok !== 1'b1) begin
      bad++; $display("FAIL up_pwrok got=%b exp=1", pwrok);
    end
    vec++;
    if (rise_t[0] !== t0 + 1) begin
      bad++; $display("FAIL up_en0 got=%0d exp=%0d", rise_t[0], t0 + 1);
    end
    for (int i = 0; i < N - 1; i++) begin
      vec++;
      if (rise_t[i+1] - rise_t[i] !== oe_lat[i] + 1) begin
        bad++;
        $display("FAIL up_step%0d got=%0d exp=%0d", i + 1,
                 rise_t[i+1] - rise_t[i], oe_lat[i] + 1);
      end
    end
    vec++;
    if (pok_t - rise_t[N-1] !== oe_lat[N-1] + 1) begin
      bad++;
      $display("FAIL up_pwrok_lat got=%0d exp=%0d",
               pok_t - rise_t[N-1], oe_lat[N-1] + 1);
    end
    vec++;
    if (en !== 4'b1111 || rc !== 2'd0) begin
      bad++; $display("FAIL up_on got=%b/%0d exp=1111/0", en, rc);
    end
  endtask

  task automatic test_nominal_down();
    int t0;
    for (int i = 0; i < N; i++) dn_lat[i] = $urandom_range(0, 4);
    req = 1'b0;
    t0 = cyc;
    tick();
    vec++;
    if (pwrok !== 1'b0 || en !== 4'b0111) begin
      bad++; $display("FAIL dn_entry got=%b/%b exp=0/0111", pwrok, en);
    end
    for (int k = 0; k < 100 && (en !== '0 || pg !== '0); k++) tick();
    ticks(3);
    vec++;
    if (fall_t[N-1] !== t0 + 1) begin
      bad++; $display("FAIL dn_en3 got=%0d exp=%0d", fall_t[N-1], t0 + 1);
    end
    for (int i = N - 1; i > 0; i--) begin
      vec++;
      if (fall_t[i-1] - fall_t[i] !== dn_lat[i] + 1) begin
        bad++;
        $display("FAIL dn_step%0d got=%0d exp=%0d", i - 1,
                 fall_t[i-1] - fall_t[i], dn_lat[i] + 1);
      end
    end
    vec++;
    if ({flat, frail, rc} !== 7'b0 || en !== '0) begin
      bad++;
      $display("FAIL dn_off got=%b %b %0d en=%b exp=0", flat, frail, rc, en);
    end
  endtask

  task automatic test_abort();
    int t0, n2;
    oe_lat[0] = $urandom_range(1, 4);
    oe_lat[1] = 10;
    n2 = rise_n[2];
    req = 1'b1;
    for (int k = 0; k < 50 && en[1] !== 1'b1; k++) tick();
    req = 1'b0;
    t0 = cyc;
    tick();
    vec++;
    if (en !== 4'b0001) begin
      bad++; $display("FAIL abort_en got=%b exp=0001", en);
    end
    for (int k = 0; k < 50 && (en !== '0 || pg !== '0); k++) tick();
    ticks(3);
    vec++;
    if (rise_n[2] !== n2 || fall_t[1] !== t0 + 1) begin
      bad++;
      $display("FAIL abort_seq got=%0d/%0d exp=%0d/%0d",
               rise_n[2], fall_t[1], n2, t0 + 1);
    end
    vec++;
    if ({flat, frail, rc} !== 7'b0) begin
      bad++; $display("FAIL abort_status got=%b %b %0d exp=0", flat, frail, rc);
    end
    oe_lat[1] = 3;
  endtask

  task automatic test_timeout();
    int n0;
    for (int i = 0; i < N; i++) begin
      oe_lat[i] = $urandom_range(1, 4);
      dn_lat[i] = $urandom_range(0, 4);
    end
    hang[2] = 1'b1;
    req = 1'b1;
    for (int k = 0; k < 100 && frail === '0; k++) tick();
    vec++;
    if (frail !== 4'b0100 || en !== 4'b0011) begin
      bad++; $display("FAIL to_frail got=%b/%b exp=0100/0011", frail, en);
    end
    vec++;
    if (cyc - rise_t[2] !== 21 || fall_t[2] !== cyc) begin
      bad++;
      $display("FAIL to_lat got=%0d exp=21", cyc - rise_t[2]);
    end
    for (int k = 0; k < 100 && rc !== 2'd1; k++) tick();
    vec++;
    if (rc !== 2'd1 || fall_t[1] - fall_t[2] !== dn_lat[2] + 1 ||
        fall_t[0] - fall_t[1] !== dn_lat[1] + 1) begin
      bad++;
      $display("FAIL to_down got=%0d %0d %0d exp=1 %0d %0d", rc,
               fall_t[1] - fall_t[2], fall_t[0] - fall_t[1],
               dn_lat[2] + 1, dn_lat[1] + 1);
    end
    vec++;
    if (rc_t !== fall_t[0] + dn_lat[0] + 1) begin
      bad++;
      $display("FAIL to_rwait got=%0d exp=%0d", rc_t, fall_t[0] + dn_lat[0] + 1);
    end
    n0 = rise_n[0];
    for (int k = 0; k < 80 && rise_n[0] === n0; k++) tick();
    vec++;
    if (rise_t[0] - rc_t !== 51) begin
      bad++; $display("FAIL to_retry got=%0d exp=51", rise_t[0] - rc_t);
    end
    hang[2] = 1'b0;
    for (int k = 0; k < 100 && pwrok !== 1'b1; k++) tick();
    vec++;
    if (pwrok !== 1'b1 || rc !== 2'd0 || frail !== 4'b0100) begin
      bad++;
      $display("FAIL to_on got=%b %0d %b exp=1 0 0100", pwrok, rc, frail);
    end
  endtask

  task automatic test_reset_mid_on();
    vec++;
    if (pwrok !== 1'b1) begin
      bad++; $display("FAIL rmo_pre got=%b exp=1", pwrok);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 1'b0;
    vec++;
    if ({en, ghi, frail} !== 12'b0 || {pwrok, flat, rc} !== 4'b0) begin
      bad++;
      $display("FAIL rmo_out got=%b %b %b %b%b %0d exp=0",
               en, ghi, frail, pwrok, flat, rc);
    end
    ticks(10);
  endtask

  task automatic test_lockout();
    int n1;
    for (int i = 0; i < N; i++) begin
      oe_lat[i] = 2;
      dn_lat[i] = $urandom_range(0, 4);
    end
    oe_lat[1] = 8;
    flt_on[1] = 1'b1;
    f_lat[1] = $urandom_range(1, 4);
    n1 = rise_n[1];
    req = 1'b1;
    for (int k = 0; k < 600 && flat !== 1'b1; k++) tick();
    vec++;
    if (flat !== 1'b1 || rc !== 2'd2 || frail !== 4'b0010) begin
      bad++; $display("FAIL lk_entry got=%b %0d %b exp=1 2 0010", flat, rc, frail);
    end
    vec++;
    if (rise_n[1] - n1 !== 3 || en !== '0) begin
      bad++;
      $display("FAIL lk_attempts got=%0d en=%b exp=3 0000", rise_n[1] - n1, en);
    end
    fclr = 1'b1;
    ticks(20);
    vec++;
    if (flat !== 1'b1 || en !== '0) begin
      bad++; $display("FAIL lk_hold got=%b/%b exp=1/0000", flat, en);
    end
    fclr = 1'b0;
    req = 1'b0;
    ticks(3);
    vec++;
    if (flat !== 1'b1) begin
      bad++; $display("FAIL lk_noclr got=%b exp=1", flat);
    end
    fclr = 1'b1;
    tick();
    fclr = 1'b0;
    vec++;
    if ({flat, frail, rc} !== 7'b0) begin
      bad++; $display("FAIL lk_clear got=%b %b %0d exp=0", flat, frail, rc);
    end
    flt_on[1] = 1'b0;
    oe_lat[1] = 3;
    ticks(5);
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      oe_lat[i] = 3;
      dn_lat[i] = 2;
      f_lat[i] = 1;
      hang[i] = 1'b0;
      flt_on[i] = 1'b0;
      age[i] = 0;
      off_age[i] = 0;
      rise_t[i] = 0;
      fall_t[i] = 0;
      rise_n[i] = 0;
    end
    test_reset();
    for (int it = 0; it < 3; it++) begin
      test_nominal_up();
      test_nominal_down();
    end
    test_abort();
    test_timeout();
    test_reset_mid_on();
    test_lockout();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

endmodule
